// File: rtl/spi_rx_fifo.sv
`timescale 1ns/1ps
// spi_rx_fifo: SPI slave receiver for the output-driver link.
// Deserialises MSB-first bytes tagged with the D/C bit into a small
// first-word-fall-through FIFO. Sticky flags report dropped bytes and
// frames that ended mid-byte.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_ARM   | after reset; wait for cs high so a running frame is never joined
// ST_IDLE  | cs high; wait for cs falling edge
// ST_SHIFT | cs low; shift one bit per SCK rising edge, push every 8th
module spi_rx_fifo #(
    parameter int DEPTH       = 8,
    parameter int AW          = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk_125mhz,
    input  logic          reset,
    input  logic          spi_cs_n,
    input  logic          spi_sck,
    input  logic          spi_sdi,
    input  logic          spi_dc,
    input  logic          rd_en,
    output logic [8:0]    rd_data,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          overflow,
    output logic          frame_err,
    input  logic          clr_err
);

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic [SYNC_STAGES-1:0] r_dc_sync;
    logic                   r_cs_q;
    logic                   r_sck_q;

    logic                   w_cs_s;
    logic                   w_sck_s;
    logic                   w_sdi_s;
    logic                   w_dc_s;
    logic                   w_sck_rise;

    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shreg;

    logic                   w_shift_en;
    logic                   w_cnt_clr;
    logic                   w_push_req;
    logic                   w_fe_set;
    logic [8:0]             w_push_data;

    logic [8:0]             r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_count;
    logic                   r_overflow;
    logic                   r_frame_err;

    logic                   w_full;
    logic                   w_pop;
    logic                   w_wr;
    logic                   w_ovf_set;

    // Synchronisers reset to 0 so a cs held low through reset reads as
    // "frame in progress" and keeps the FSM in ARM.
    always_ff @(posedge clk_125mhz or posedge reset) begin
        if (reset) begin
            r_cs_sync  <= '0;
            r_sck_sync <= '0;
            r_sdi_sync <= '0;
            r_dc_sync  <= '0;
            r_cs_q     <= 1'b0;
            r_sck_q    <= 1'b0;
        end else begin
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0],  spi_cs_n};
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
            r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], spi_sdi};
            r_dc_sync  <= {r_dc_sync[SYNC_STAGES-2:0],  spi_dc};
            r_cs_q     <= w_cs_s;
            r_sck_q    <= w_sck_s;
        end
    end

    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_sck_s     = r_sck_sync[SYNC_STAGES-1];
    assign w_sdi_s     = r_sdi_sync[SYNC_STAGES-1];
    assign w_dc_s      = r_dc_sync[SYNC_STAGES-1];
    assign w_sck_rise  = w_sck_s & ~r_sck_q;
    assign w_push_data = {w_dc_s, r_shreg[6:0], w_sdi_s};

    // FSM state register
    always_ff @(posedge clk_125mhz or posedge reset) begin
        if (reset) r_state <= ST_ARM;
        else       r_state <= w_state_nxt;
    end

    // Next-state and per-cycle strobes; cs high beats a coincident SCK rise
    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_cnt_clr   = 1'b0;
        w_push_req  = 1'b0;
        w_fe_set    = 1'b0;
        case (r_state)
            ST_ARM: begin
                if (w_cs_s) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (r_cs_q && !w_cs_s) begin
                    w_state_nxt = ST_SHIFT;
                    w_cnt_clr   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_cs_s) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_clr   = 1'b1;
                    w_fe_set    = (r_bit_cnt != 3'd0);
                end else if (w_sck_rise) begin
                    w_shift_en = 1'b1;
                    w_push_req = (r_bit_cnt == 3'd7);
                end
            end
            default: w_state_nxt = ST_ARM;
        endcase
    end

    // Shift register and bit counter; the 3-bit counter wraps 7->0 on a push
    always_ff @(posedge clk_125mhz or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= 3'd0;
            r_shreg   <= 8'd0;
        end else if (w_cnt_clr) begin
            r_bit_cnt <= 3'd0;
        end else if (w_shift_en) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_shreg   <= {r_shreg[6:0], w_sdi_s};
        end
    end

    assign w_full    = (r_count == CNT_FULL);
    assign w_pop     = rd_en & (r_count != '0);
    assign w_wr      = w_push_req & (~w_full | w_pop);
    assign w_ovf_set = w_push_req & w_full & ~w_pop;

    // FIFO storage; no reset needed since rd_data is masked when empty
    always_ff @(posedge clk_125mhz) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_push_data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_125mhz or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a set event outranks clr_err in the same cycle
    always_ff @(posedge clk_125mhz or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_ovf_set)    r_overflow <= 1'b1;
            else if (clr_err) r_overflow <= 1'b0;
            if (w_fe_set)     r_frame_err <= 1'b1;
            else if (clr_err) r_frame_err <= 1'b0;
        end
    end

    assign rd_valid  = (r_count != '0);
    assign rd_data   = rd_valid ? r_mem[r_rd_ptr] : 9'h000;
    assign count     = r_count;
    assign busy      = (r_state == ST_SHIFT);
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_rx_fifo.sv
`timescale 1ns/1ps
// Bench for spi_rx_fifo: directed scenarios plus random frames, checked
// against a queue-based model of the received byte stream.
module tb_spi_rx_fifo;

    localparam int H     = 50;
    localparam int DEPTH = 8;

    logic       clk_125mhz = 1'b0;
    logic       reset      = 1'b1;
    logic       spi_cs_n   = 1'b1;
    logic       spi_sck    = 1'b1;
    logic       spi_sdi    = 1'b0;
    logic       spi_dc     = 1'b0;
    logic       rd_en      = 1'b0;
    logic       clr_err    = 1'b0;
    logic [8:0] rd_data;
    logic       rd_valid;
    logic [3:0] count;
    logic       busy;
    logic       overflow;
    logic       frame_err;

    int         errors = 0;
    int         checks = 0;

    logic [8:0] mq[$];
    logic       m_ovf = 1'b0;
    logic       m_fe  = 1'b0;
    logic       cur_dc = 1'b0;

    spi_rx_fifo #(.DEPTH(8), .AW(3), .SYNC_STAGES(2)) dut (
        .clk_125mhz (clk_125mhz),
        .reset      (reset),
        .spi_cs_n   (spi_cs_n),
        .spi_sck    (spi_sck),
        .spi_sdi    (spi_sdi),
        .spi_dc     (spi_dc),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .count      (count),
        .busy       (busy),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .clr_err    (clr_err)
    );

    always #4 clk_125mhz = ~clk_125mhz;

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk_125mhz);
        #1;
    endtask

    task automatic m_push(input logic [8:0] v);
        if (mq.size() >= DEPTH) m_ovf = 1'b1;
        else                    mq.push_back(v);
    endtask

    task automatic check_all(input string tag, input logic exp_busy);
        logic [3:0] e_cnt;
        logic       e_val;
        logic [8:0] e_dat;
        e_cnt = 4'(mq.size());
        e_val = (mq.size() > 0);
        e_dat = (mq.size() > 0) ? mq[0] : 9'h000;
        checks++;
        assert (count === e_cnt) else begin
            errors++; $error("FAIL %s count got=%0d exp=%0d", tag, count, e_cnt);
        end
        checks++;
        assert (rd_valid === e_val) else begin
            errors++; $error("FAIL %s rd_valid got=%0b exp=%0b", tag, rd_valid, e_val);
        end
        checks++;
        assert (rd_data === e_dat) else begin
            errors++; $error("FAIL %s rd_data got=%h exp=%h", tag, rd_data, e_dat);
        end
        checks++;
        assert (overflow === m_ovf) else begin
            errors++; $error("FAIL %s overflow got=%0b exp=%0b", tag, overflow, m_ovf);
        end
        checks++;
        assert (frame_err === m_fe) else begin
            errors++; $error("FAIL %s frame_err got=%0b exp=%0b", tag, frame_err, m_fe);
        end
        checks++;
        assert (busy === exp_busy) else begin
            errors++; $error("FAIL %s busy got=%0b exp=%0b", tag, busy, exp_busy);
        end
    endtask

    task automatic frame_begin(input logic dc);
        cur_dc   = dc;
        spi_dc   = dc;
        spi_cs_n = 1'b0;
        clk_wait(10);
    endtask

    task automatic frame_end(input logic partial);
        spi_cs_n = 1'b1;
        clk_wait(10);
        if (partial) m_fe = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        spi_sck = 1'b0;
        spi_sdi = b;
        clk_wait(H);
        spi_sck = 1'b1;
        clk_wait(H);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
    endtask

    // side: 0 none, 1 rd_en in the push cycle, 2 clr_err in the push cycle.
    // The rise is driven 1ns after an edge; two synchroniser edges later the
    // rise is seen and the FIFO write lands on the third edge.
    task automatic send_byte(input logic [7:0] b, input int side);
        send_bits(b, 7);
        spi_sck = 1'b0;
        spi_sdi = b[0];
        clk_wait(H);
        spi_sck = 1'b1;
        clk_wait(2);
        if (side == 1) rd_en = 1'b1;
        if (side == 2) clr_err = 1'b1;
        clk_wait(1);
        rd_en   = 1'b0;
        clr_err = 1'b0;
        if (side == 1 && mq.size() > 0) void'(mq.pop_front());
        if (side == 2) begin m_ovf = 1'b0; m_fe = 1'b0; end
        m_push({cur_dc, b});
        clk_wait(H - 3);
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        clk_wait(1);
        rd_en = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic clr_pulse();
        clr_err = 1'b1;
        clk_wait(1);
        clr_err = 1'b0;
        m_ovf = 1'b0;
        m_fe  = 1'b0;
    endtask

    initial begin
        int nb;
        int np;
        logic [7:0] rb;

        // reset state
        clk_wait(3);
        check_all("reset", 1'b0);
        reset = 1'b0;
        clk_wait(10);
        check_all("post_reset", 1'b0);

        // single byte, dc=1
        frame_begin(1'b1);
        send_byte(8'hA5, 0);
        frame_end(1'b0);
        check_all("t1_a5", 1'b0);
        pop_one();
        check_all("t1_pop", 1'b0);

        // two bytes in one frame, dc=0
        frame_begin(1'b0);
        send_byte(8'h3C, 0);
        send_byte(8'hC3, 0);
        frame_end(1'b0);
        check_all("t2_two", 1'b0);
        pop_one();
        check_all("t2_pop1", 1'b0);
        pop_one();
        check_all("t2_pop2", 1'b0);
        pop_one();
        check_all("t2_pop_empty", 1'b0);

        // nine bytes into eight entries
        frame_begin(1'b0);
        for (int i = 0; i < 9; i++) send_byte(8'(i), 0);
        frame_end(1'b0);
        check_all("t3_full", 1'b0);
        for (int i = 0; i < 8; i++) begin
            pop_one();
            check_all("t3_drain", 1'b0);
        end
        clr_pulse();
        check_all("t3_clr", 1'b0);

        // frame aborted after 5 bits
        frame_begin(1'b1);
        send_bits(8'hF0, 5);
        check_all("t4_mid", 1'b1);
        frame_end(1'b1);
        check_all("t4_fe", 1'b0);
        frame_begin(1'b1);
        send_byte(8'h5A, 0);
        frame_end(1'b0);
        check_all("t4_5a", 1'b0);
        pop_one();
        clr_pulse();
        check_all("t4_clr", 1'b0);

        // full FIFO, pop in the push cycle
        frame_begin(1'b1);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
        check_all("t5_full", 1'b1);
        send_byte(8'hE7, 1);
        frame_end(1'b0);
        check_all("t5_pushpop", 1'b0);
        for (int i = 0; i < 8; i++) begin
            pop_one();
            check_all("t5_drain", 1'b0);
        end

        // full FIFO, clr_err coincident with the overflow event
        frame_begin(1'b0);
        for (int i = 0; i < 9; i++) send_byte(8'($urandom), (i == 8) ? 2 : 0);
        frame_end(1'b0);
        check_all("t5_setwins", 1'b0);
        while (mq.size() > 0) pop_one();
        clr_pulse();
        check_all("t5_empty", 1'b0);

        // reset in the middle of a frame, released with cs still low
        frame_begin(1'b0);
        send_bits(8'h81, 3);
        reset = 1'b1;
        clk_wait(3);
        mq.delete();
        m_ovf = 1'b0;
        m_fe  = 1'b0;
        check_all("t6_in_reset", 1'b0);
        reset = 1'b0;
        clk_wait(5);
        for (int i = 4; i >= 0; i--) send_bit(1'(8'h81 >> i));
        check_all("t6_ignored", 1'b0);
        frame_end(1'b0);
        check_all("t6_after", 1'b0);
        frame_begin(1'b0);
        send_byte(8'h81, 0);
        frame_end(1'b0);
        check_all("t6_81", 1'b0);
        pop_one();

        // random frames with random pops and occasional aborted tails
        for (int f = 0; f < 5; f++) begin
            frame_begin(1'($urandom_range(0, 1)));
            nb = $urandom_range(1, 3);
            for (int i = 0; i < nb; i++) send_byte(8'($urandom), 0);
            if ($urandom_range(0, 3) == 0) begin
                rb = 8'($urandom);
                send_bits(rb, $urandom_range(1, 7));
                frame_end(1'b1);
            end else begin
                frame_end(1'b0);
            end
            check_all("rand_frame", 1'b0);
            np = $urandom_range(0, mq.size() + 1);
            for (int i = 0; i < np; i++) begin
                pop_one();
                check_all("rand_pop", 1'b0);
            end
            if ($urandom_range(0, 2) == 0) begin
                clr_pulse();
                check_all("rand_clr", 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
